// File: rtl/conv_sequencer_if.sv
// Control and SRAM-side bundle of the convolution sequencer.
// master = environment / datapath side, slave = sequencer side.
interface conv_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 8
);
  logic              dut_run;
  logic [2:0]        k_size;
  logic              stride2;
  logic              dut_busy;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic [DIM_W-1:0]  nrows_q;
  logic [DIM_W-1:0]  ncols_q;
  logic              row_load;
  logic [DIM_W-1:0]  col_idx;
  logic              win_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              skip_err;

  modport master (
    output dut_run, k_size, stride2, rd_data,
    input  dut_busy, rd_addr, nrows_q, ncols_q, row_load, col_idx,
           win_valid, wr_en, wr_addr, skip_err
  );
  modport slave (
    input  dut_run, k_size, stride2, rd_data,
    output dut_busy, rd_addr, nrows_q, ncols_q, row_load, col_idx,
           win_valid, wr_en, wr_addr, skip_err
  );
endinterface

// File: rtl/conv_sequencer.sv
// Walks a list of images in SRAM, feeding K rows then S rows per output row to a
// sliding-window datapath and emitting one output-row write per window row.
module conv_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 8,
  parameter int KMAX   = 5
) (
  input logic              clk,
  input logic              reset,
  conv_sequencer_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE, DIMR, DIMC, CHK, FILL, COLS, ROWEND, ADV, SKIP, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] img_ptr_q, img_ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DIM_W-1:0]  nrows_q, nrows_d, ncols_q, ncols_d;
  logic [DIM_W-1:0]  k_q, k_d;
  logic              s2_q, s2_d;
  logic [DIM_W-1:0]  cnt_q, cnt_d;
  logic [DIM_W-1:0]  fill_n_q, fill_n_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  orow_q, orow_d;
  logic              busy_q, busy_d;

  logic [DIM_W-1:0]  k_eff, s_w, or_w, oc_w;
  logic [ADDR_W-1:0] next_img;

  always_comb begin
    if (bus.k_size == 3'd0)                     k_eff = DIM_W'(1);
    else if (DIM_W'(bus.k_size) > DIM_W'(KMAX)) k_eff = DIM_W'(KMAX);
    else                                        k_eff = DIM_W'(bus.k_size);
  end

  // Dimensions are only consumed after CHK has guaranteed nrows/ncols >= K.
  assign s_w      = s2_q ? DIM_W'(2) : DIM_W'(1);
  assign or_w     = ((nrows_q - k_q) >> s2_q) + DIM_W'(1);
  assign oc_w     = ((ncols_q - k_q) >> s2_q) + DIM_W'(1);
  assign next_img = img_ptr_q + ADDR_W'(2) + ADDR_W'(nrows_q);

  always_comb begin
    state_d   = state_q;
    img_ptr_d = img_ptr_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    nrows_d   = nrows_q;
    ncols_d   = ncols_q;
    k_d       = k_q;
    s2_d      = s2_q;
    cnt_d     = cnt_q;
    fill_n_d  = fill_n_q;
    col_d     = col_q;
    orow_d    = orow_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: if (bus.dut_run) begin
        k_d = k_eff; s2_d = bus.stride2;
        img_ptr_d = '0; wr_addr_d = '0; rd_addr_d = '0;
        busy_d = 1'b1; state_d = DIMR;
      end
      DIMR: begin
        rd_addr_d = img_ptr_q + ADDR_W'(1);
        state_d   = DIMC;
      end
      DIMC: begin
        if (bus.rd_data == 16'hFFFF) state_d = DONE;
        else begin
          nrows_d   = bus.rd_data[DIM_W-1:0];
          rd_addr_d = img_ptr_q + ADDR_W'(2);
          state_d   = CHK;
        end
      end
      CHK: begin
        ncols_d = bus.rd_data[DIM_W-1:0];
        if (nrows_q < k_q || ncols_d < k_q) state_d = SKIP;
        else begin
          cnt_d = '0; fill_n_d = k_q; orow_d = '0; state_d = FILL;
        end
      end
      // Reads issue on cnt 0..n-1; each returns a cycle later, hence n+1 cycles.
      FILL: begin
        if (cnt_q == fill_n_q) begin
          cnt_d = '0; col_d = '0; state_d = COLS;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          cnt_d     = cnt_q + DIM_W'(1);
        end
      end
      COLS: begin
        col_d = col_q + s_w;
        cnt_d = cnt_q + DIM_W'(1);
        if (cnt_q == oc_w - DIM_W'(1)) begin
          cnt_d = '0; col_d = '0; state_d = ROWEND;
        end
      end
      ROWEND: begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        if (orow_q == or_w - DIM_W'(1)) state_d = ADV;
        else begin
          orow_d = orow_q + DIM_W'(1);
          fill_n_d = s_w; cnt_d = '0; state_d = FILL;
        end
      end
      ADV, SKIP: begin
        img_ptr_d = next_img;
        rd_addr_d = next_img;
        state_d   = DIMR;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;   img_ptr_q <= '0; rd_addr_q <= '0; wr_addr_q <= '0;
      nrows_q <= '0;     ncols_q <= '0;   k_q <= DIM_W'(1); s2_q <= 1'b0;
      cnt_q <= '0;       fill_n_q <= '0;  col_q <= '0;     orow_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d; img_ptr_q <= img_ptr_d; rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d; nrows_q <= nrows_d; ncols_q <= ncols_d;
      k_q <= k_d; s2_q <= s2_d; cnt_q <= cnt_d; fill_n_q <= fill_n_d;
      col_q <= col_d; orow_q <= orow_d; busy_q <= busy_d;
    end
  end

  assign bus.dut_busy  = busy_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.nrows_q   = nrows_q;
  assign bus.ncols_q   = ncols_q;
  assign bus.col_idx   = col_q;
  assign bus.row_load  = (state_q == FILL) && (cnt_q != '0);
  assign bus.win_valid = (state_q == COLS);
  assign bus.wr_en     = (state_q == ROWEND);
  assign bus.skip_err  = (state_q == SKIP);
endmodule
